fetch_decode_unit: RTL

- Instruction fetch/decode sequencer directly upstream of the 4-bit execute unit.
- Holds a 16-entry program store, a program counter and a one-entry return register.
- Fetches and splits each instruction into the execute unit's opcode bits (A3..A0) and operand buses (A, B, BYTE, address, address_val).
- Resolves control flow (JZ/JMP/CALL/RET/HLT) locally so execution proceeds without host intervention.

---
 rtl/fetch_decode_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit
// Instruction fetch/decode sequencer feeding the 4-bit execute unit.
// Holds a 16-entry program store, a program counter and a one-entry return
// register. Each instruction takes three cycles (FETCH, ISSUE, WAIT). Its
// fields are presented on registered outputs with a one-cycle issue strobe.
// Control flow (JZ/JMP/CALL/RET/HLT) is resolved locally.
//
// Ports:
//   clk, rst               rising-edge clock, async active-high reset
//   load_en/addr/data      program-store write port (IDLE and HALT only)
//   start                  begin execution at pc 0 (IDLE only)
//   ZF_in                  zero flag from execute unit, sampled at end of ISSUE
//   A3..A0                 opcode bits [15:12]
//   A, B                   operand fields [11:8], [7:4]
//   BYTE/address/address_val  immediate field [3:0]
//   issue                  one-cycle strobe: outputs carry a new instruction
//   pc                     address of the instruction issued/held
//   busy, halted           FETCH/ISSUE/WAIT, HALT status
module fetch_decode_unit #(
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned INSTR_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [3:0]         load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    input  logic               ZF_in,
    output logic               A3,
    output logic               A2,
    output logic               A1,
    output logic               A0,
    output logic [3:0]         A,
    output logic [3:0]         B,
    output logic [3:0]         BYTE,
    output logic [3:0]         address,
    output logic [3:0]         address_val,
    output logic               issue,
    output logic [3:0]         pc,
    output logic               busy,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_JZ   = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd7;
    localparam logic [3:0] OP_CALL = 4'd12;
    localparam logic [3:0] OP_RET  = 4'd13;
    localparam logic [3:0] OP_HLT  = 4'd15;

    state_t             state, state_nx;
    logic [INSTR_W-1:0] mem [0:PROG_DEPTH-1];
    logic [INSTR_W-1:0] fetch_word;
    logic [3:0]         op_q, imm_q, ret_q, pc_nx;
    logic               zf_q;

    assign fetch_word  = mem[pc];
    assign {A3, A2, A1, A0} = op_q;
    assign BYTE        = imm_q;
    assign address     = imm_q;
    assign address_val = imm_q;

    // Store has no reset so its contents survive rst; writes only when idle
    // or halted so a running program cannot be modified underneath itself.
    always_ff @(posedge clk) begin
        if (load_en && (state == S_IDLE || state == S_HALT)) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  state_nx = (op_q == OP_HLT) ? S_HALT : S_FETCH;
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        pc_nx = pc + 4'd1;
        case (op_q)
            OP_JZ:   if (zf_q) pc_nx = imm_q;
            OP_JMP:  pc_nx = imm_q;
            OP_CALL: pc_nx = imm_q;
            OP_RET:  pc_nx = ret_q;
            OP_HLT:  pc_nx = pc;
            default: pc_nx = pc + 4'd1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= '0;
            ret_q  <= '0;
            op_q   <= '0;
            A      <= '0;
            B      <= '0;
            imm_q  <= '0;
            zf_q   <= 1'b0;
            issue  <= 1'b0;
            busy   <= 1'b0;
            halted <= 1'b0;
        end else begin
            state  <= state_nx;
            issue  <= (state == S_FETCH);
            busy   <= (state_nx == S_FETCH) || (state_nx == S_ISSUE) || (state_nx == S_WAIT);
            halted <= (state_nx == S_HALT);
            case (state)
                S_IDLE: begin
                    if (start) pc <= '0;
                end
                S_FETCH: begin
                    // Decoded fields double as the instruction register.
                    op_q  <= fetch_word[15:12];
                    A     <= fetch_word[11:8];
                    B     <= fetch_word[7:4];
                    imm_q <= fetch_word[3:0];
                end
                S_ISSUE: begin
                    zf_q <= ZF_in;
                end
                S_WAIT: begin
                    pc <= pc_nx;
                    if (op_q == OP_CALL) ret_q <= pc + 4'd1;
                    else if (op_q == OP_RET) ret_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
